cnt_ctrl: RTL and testbench
===========================

# cnt_ctrl

Sequencing controller that sits on the far side of the team's loadable up-counter, whose ports are ld, initld, en and co. It drives ld, initld and en, and consumes the counter's co (terminal-count) output. Each command runs a programmable number of rounds of a programmable length, then reports completion with a one-cycle done pulse. It is the initiator for timed phases, e.g. a fixed number of data beats per round, repeated a given number of times.

## Interface
Parameters:
- N, 6: counter width; must match the attached counter.
- R, 4: width of the round-count field.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  command strobe; sampled only in IDLE.
- len  input  N  enabled cycles per round; 0 means 2^N.
- reps  input  R  number of rounds; 0 means no rounds.
- hold  input  1  freezes counting while high.
- abort  input  1  cancels the command in progress.
- co  input  1  counter terminal count: high when the counter's en is high and its value is all ones.
- ld  output  1  counter load strobe.
- initld  output  N  counter load value.
- en  output  1  counter count enable.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle completion pulse.
- rounds_left  output  R  rounds remaining, including the current one.

## Operation
States:
- IDLE: ld=0, en=0, busy=0.
  - start=1 with reps≠0: latch len_q=len and rounds_left=reps; go to LOAD.
  - start=1 with reps=0: go to DONE, no ld issued.
  - Otherwise stay in IDLE.
- LOAD: ld=1, en=0, initld=(-len_q) mod 2^N, i.e. ~len_q+1 truncated to N bits. Next state is RUN unconditionally.
- RUN: ld=0, en=~hold (combinational from hold). On co=1:
  - rounds_left>1: decrement rounds_left, go to LOAD.
  - rounds_left==1: set rounds_left=0, go to DONE.
  - With co=0, stay in RUN.
- DONE: done=1, busy=1; go to IDLE.

Rules:
- initld holds its value outside LOAD; it is don't-care but must be stable.
- Length arithmetic: the counter reaches all-ones after exactly len_q enabled increments from the load value, so co rises on the len_q-th en=1 cycle. len_q=0 yields initld=0 and 2^N enabled cycles.
- abort=1 in any non-IDLE state: next state IDLE, rounds_left=0, no done pulse. abort beats co in the same cycle. abort in IDLE is ignored.
- start while busy is ignored; len and reps changes after latching have no effect.
- hold=1 in RUN: en=0, so co stays 0 and no round ends. hold has no effect in other states. hold together with abort: abort wins.
- co is used only in RUN. A co during LOAD, DONE or IDLE is ignored (cannot legally occur).

## Timing
- Reset: state=IDLE, ld=0, en=0, busy=0, done=0, rounds_left=0, initld=0. Reset applies immediately and asynchronously, including mid-round. The attached counter must share rst.
- ld, busy, done, rounds_left and initld are Moore outputs decoded from registered state. en is additionally gated combinationally by hold.
- Latency: start at edge t gives LOAD during cycle t+1.
- A round is 1 LOAD cycle plus len_q RUN cycles, plus any cycles with hold=1.
- Without hold:
  - Last co occurs in cycle t+reps·(len_q+1).
  - done occurs in cycle t+reps·(len_q+1)+1.
  - The next start is accepted in the cycle after done.
- reps=0: done in cycle t+1.

## Test plan
- N=6, len=5, reps=1, start at cycle 0:
  - ld=1 and initld=59 in cycle 1.
  - en=1 in cycles 2–6.
  - co in cycle 6.
  - done in cycle 7; busy high in cycles 1–7.
- len=0, reps=1: initld=0, 64 en cycles, co at the 64th, done one cycle later.
- len=2, reps=3: three ld pulses with initld=62 in cycles 1, 4 and 7. rounds_left steps 3→2→1→0. done in cycle 10.
- len=4, reps=1, hold=1 for cycles 3–5: en low for those 3 cycles, co in cycle 8, done in cycle 9.
- abort in cycle 3 of a len=4, reps=2 run: IDLE from cycle 4, no done, rounds_left=0. Then start with reps=0 gives done the next cycle.
- rst asserted mid-RUN: all outputs go to 0 immediately. start during busy is ignored, with no change to rounds_left.

Source files
------------

// File: rtl/cnt_ctrl.sv
// Sequencing controller for the loadable up-counter: runs a programmed number of
// rounds of a programmed length, then emits a one-cycle done pulse.
module cnt_ctrl #(
    parameter int N = 6,
    parameter int R = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] len,
    input  logic [R-1:0] reps,
    input  logic         hold,
    input  logic         abort,
    input  logic         co,
    output logic         ld,
    output logic [N-1:0] initld,
    output logic         en,
    output logic         busy,
    output logic         done,
    output logic [R-1:0] rounds_left
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t       state;
    state_t       nextState;
    logic [N-1:0] len_q;
    logic [R-1:0] roundsNext;
    logic         lenLatch;

    // State, latched length and round count; everything else is decoded from these.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            len_q       <= '0;
            rounds_left <= '0;
        end else begin
            state       <= nextState;
            rounds_left <= roundsNext;
            if (lenLatch) begin
                len_q <= len;
            end
        end
    end

    // Next-state and output decode; abort overrides every other transition out of a busy state.
    always_comb begin
        nextState  = state;
        roundsNext = rounds_left;
        lenLatch   = 1'b0;
        ld         = 1'b0;
        en         = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (reps != '0) begin
                        lenLatch   = 1'b1;
                        roundsNext = reps;
                        nextState  = LOAD;
                    end else begin
                        nextState = DONE;
                    end
                end
            end
            LOAD: begin
                ld        = 1'b1;
                nextState = RUN;
            end
            RUN: begin
                en = ~hold;
                if (co) begin
                    if (rounds_left > R'(1)) begin
                        roundsNext = rounds_left - R'(1);
                        nextState  = LOAD;
                    end else begin
                        roundsNext = '0;
                        nextState  = DONE;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
        if (abort && (state != IDLE)) begin
            nextState  = IDLE;
            roundsNext = '0;
        end
    end

    // Loading the two's complement makes the counter hit all-ones after exactly len_q
    // increments; len_q = 0 wraps to a full 2^N-cycle round.
    assign initld = -len_q;

endmodule

// File: tb/tb_cnt_ctrl.sv
// Self-checking bench for cnt_ctrl: a behavioural counter closes the loop and each
// command is expanded into an expected cycle-by-cycle timeline before it is driven.
module tb_cnt_ctrl;

    localparam int N = 6;
    localparam int R = 4;
    localparam int FULL = 1 << N;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] len;
    logic [R-1:0] reps;
    logic         hold;
    logic         abort;
    logic         co;
    logic         ld;
    logic [N-1:0] initld;
    logic         en;
    logic         busy;
    logic         done;
    logic [R-1:0] rounds_left;

    logic [N-1:0] cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int ld;
        int en;
        int co;
        int busy;
        int done;
        int rl;
        int hold;
    } step_t;

    step_t sched[$];

    cnt_ctrl #(.N(N), .R(R)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .len(len),
        .reps(reps),
        .hold(hold),
        .abort(abort),
        .co(co),
        .ld(ld),
        .initld(initld),
        .en(en),
        .busy(busy),
        .done(done),
        .rounds_left(rounds_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The attached loadable up-counter, sharing rst with the controller.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= initld;
        end else if (en) begin
            cnt <= cnt + N'(1);
        end
    end

    assign co = en && (cnt == {N{1'b1}});

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".ld"}, int'(ld), 0);
        checkOutput({tag, ".en"}, int'(en), 0);
        checkOutput({tag, ".busy"}, int'(busy), 0);
        checkOutput({tag, ".done"}, int'(done), 0);
        checkOutput({tag, ".rounds_left"}, int'(rounds_left), 0);
    endtask

    function automatic int pickHold(input int c, input int holdPct, input int holdLo, input int holdHi);
        if (c >= holdLo && c <= holdHi) return 1;
        if (int'($urandom_range(99)) < holdPct) return 1;
        return 0;
    endfunction

    // One command: start in cycle 0, expected timeline for cycles 1.. built from the round rules.
    // abortAt > 0 aborts in that cycle, abortAt < 0 picks a random busy cycle, 0 means no abort.
    task automatic applyStimulus(input string tag, input int lenIn, input int repsIn,
                                 input int holdPct, input int holdLo, input int holdHi,
                                 input int abortAt);
        int    beats;
        int    c;
        int    roundLen;
        int    abortCycle;
        int    expInit;
        step_t s;

        roundLen = (lenIn == 0) ? FULL : lenIn;
        expInit  = (FULL - roundLen) % FULL;
        sched.delete();
        c = 1;
        if (repsIn != 0) begin
            for (int r = 0; r < repsIn; r++) begin
                s = '{ld: 1, en: 0, co: 0, busy: 1, done: 0, rl: repsIn - r,
                      hold: pickHold(c, holdPct, holdLo, holdHi)};
                sched.push_back(s);
                c++;
                beats = 0;
                while (beats < roundLen) begin
                    s.ld   = 0;
                    s.hold = pickHold(c, holdPct, holdLo, holdHi);
                    s.en   = (s.hold == 0) ? 1 : 0;
                    beats += s.en;
                    s.co   = (s.en == 1 && beats == roundLen) ? 1 : 0;
                    sched.push_back(s);
                    c++;
                end
            end
        end
        s = '{ld: 0, en: 0, co: 0, busy: 1, done: 1, rl: 0, hold: int'($urandom_range(1))};
        sched.push_back(s);

        abortCycle = abortAt;
        if (abortAt < 0) begin
            abortCycle = (sched.size() > 1) ? int'($urandom_range(sched.size() - 1, 1)) : 0;
        end

        @(posedge clk);
        #1;
        start = 1'b1;
        len   = N'(lenIn);
        reps  = R'(repsIn);
        abort = 1'b0;
        hold  = 1'($urandom_range(1));
        #1;
        checkIdle({tag, ".pre"});

        for (int i = 0; i < sched.size(); i++) begin
            @(posedge clk);
            #1;
            start = 1'($urandom_range(1));
            len   = N'($urandom);
            reps  = R'($urandom);
            abort = (i + 1 == abortCycle);
            hold  = 1'(sched[i].hold);
            #1;
            checkOutput({tag, ".ld"}, int'(ld), sched[i].ld);
            checkOutput({tag, ".en"}, int'(en), sched[i].en);
            checkOutput({tag, ".co"}, int'(co), sched[i].co);
            checkOutput({tag, ".busy"}, int'(busy), sched[i].busy);
            checkOutput({tag, ".done"}, int'(done), sched[i].done);
            checkOutput({tag, ".rounds_left"}, int'(rounds_left), sched[i].rl);
            if (sched[i].ld == 1) begin
                checkOutput({tag, ".initld"}, int'(initld), expInit);
            end
            if (abort) break;
        end

        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        hold  = 1'b0;
        #1;
        checkIdle({tag, ".post"});
    endtask

    // Asynchronous reset in the middle of a RUN cycle must clear outputs before any edge.
    task automatic applyMidRunReset();
        @(posedge clk);
        #1;
        start = 1'b1;
        len   = N'(10);
        reps  = R'(3);
        hold  = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        #1;
        checkOutput("rst.en_before", int'(en), 1);
        checkOutput("rst.rl_before", int'(rounds_left), 3);
        #2;
        rst = 1'b1;
        #1;
        checkIdle("rst.async");
        checkOutput("rst.initld", int'(initld), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkIdle("rst.after");
    endtask

    initial begin
        int lenR;
        int repsR;
        rst   = 1'b1;
        start = 1'b0;
        len   = '0;
        reps  = '0;
        hold  = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkIdle("reset");
        checkOutput("reset.initld", int'(initld), 0);
        rst = 1'b0;

        applyStimulus("len5", 5, 1, 0, 1, 0, 0);
        applyStimulus("len0", 0, 1, 0, 1, 0, 0);
        applyStimulus("len2x3", 2, 3, 0, 1, 0, 0);
        applyStimulus("hold", 4, 1, 0, 3, 5, 0);
        applyStimulus("abort", 4, 2, 0, 1, 0, 3);
        applyStimulus("reps0", 7, 0, 0, 1, 0, 0);
        applyMidRunReset();
        applyStimulus("postrst", 3, 2, 20, 1, 0, 0);

        for (int k = 0; k < 25; k++) begin
            lenR  = ($urandom_range(3) == 0) ? int'($urandom_range(FULL - 1)) : int'($urandom_range(8));
            repsR = int'($urandom_range((1 << R) - 1));
            applyStimulus($sformatf("rand%0d", k), lenR, repsR, int'($urandom_range(30)), 1, 0,
                          ($urandom_range(4) == 0) ? -1 : 0);
        end

        $display("[TB] all commands issued");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
